// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit unsigned multiply/divide feeding the register-file write port,
// 32 steps per operation, result held on the write bundle until WB_GRANT.
module muldiv_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [31:0] OPERAND_A,
    input  logic [31:0] OPERAND_B,
    input  logic [4:0]  DEST,
    input  logic        WB_GRANT,
    output logic        BUSY,
    output logic        DONE,
    output logic        WRITE_ENABLE,
    output logic [4:0]  ADDRESS_WRITE,
    output logic [31:0] DATA_WRITE
);
    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] b_q;
    logic [4:0]  dest_q;
    logic [32:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [32:0] sum, shl, diff;
    logic        start_ok, last_step;

    assign start_ok  = (state_q == IDLE) && START;
    assign last_step = (state_q == CALC) && (cnt_q == 5'd31);

    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = start_ok ? CALC :
                  last_step ? WB :
                  (state_q == WB && WB_GRANT) ? IDLE : state_q;
    end

    always_comb begin
        BUSY         = state_q != IDLE;
        WRITE_ENABLE = state_q == WB;
        DONE         = (state_q == WB) && WB_GRANT;
    end

    // hi/lo double as {hi,lo} product for multiply and {remainder,quotient} for divide
    always_comb begin
        sum  = {1'b0, hi_q[31:0]} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        shl  = {hi_q[31:0], lo_q[31]};
        diff = shl - {1'b0, b_q};
        hi_d = op_q[1] ? (diff[32] ? shl : diff) : {1'b0, sum[32:1]};
        lo_d = op_q[1] ? {lo_q[30:0], ~diff[32]} : {sum[0], lo_q[31:1]};
    end

    always_ff @(posedge CLK) begin
        if (start_ok) begin
            op_q   <= OP;
            b_q    <= OPERAND_B;
            dest_q <= DEST;
            hi_q   <= 33'd0;
            lo_q   <= OPERAND_A;
        end else if (state_q == CALC) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q  <= 5'd0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
        end else begin
            if (start_ok) cnt_q <= 5'd0;
            else if (state_q == CALC) cnt_q <= cnt_q + 5'd1;
            if (last_step) begin
                addr_q <= dest_q;
                data_q <= op_q[0] ? hi_d[31:0] : lo_d;
            end
        end
    end

    assign ADDRESS_WRITE = addr_q;
    assign DATA_WRITE    = data_q;
endmodule
